// File: rtl/rx_status_pkg.sv
// ----------------------------------------------------------------------------
// rx_status_pkg
// Shared constants for the registered multi-lane PIPE RxStatus tracker:
//   - RxStatus codes (seven events plus idle)
//   - bit indices of the per-lane 7-bit event vector
//   - bit indices of the per-lane 4-bit sticky error vector
// The event vector is ordered so that bit i reports as code i+1. The
// highest set bit is therefore also the highest-priority event.
// ----------------------------------------------------------------------------
package rx_status_pkg;

    localparam int NUM_EV  = 7;
    localparam int NUM_ERR = 4;

    localparam logic [2:0] CODE_IDLE      = 3'b000;
    localparam logic [2:0] CODE_SKIP_ADD  = 3'b001;
    localparam logic [2:0] CODE_SKIP_REM  = 3'b010;
    localparam logic [2:0] CODE_RX_DET    = 3'b011;
    localparam logic [2:0] CODE_DEC_ERR   = 3'b100;
    localparam logic [2:0] CODE_OVERFLOW  = 3'b101;
    localparam logic [2:0] CODE_UNDERFLOW = 3'b110;
    localparam logic [2:0] CODE_DISP_ERR  = 3'b111;

    // Event vector bit positions (bit i <-> code i+1).
    localparam int EV_SKIP_ADD  = 0;
    localparam int EV_SKIP_REM  = 1;
    localparam int EV_RX_DET    = 2;
    localparam int EV_DEC_ERR   = 3;
    localparam int EV_OVERFLOW  = 4;
    localparam int EV_UNDERFLOW = 5;
    localparam int EV_DISP_ERR  = 6;

    // Sticky flag order, MSB first: {Disparity, underflow, overflow, Decode}.
    localparam int STK_DEC  = 0;
    localparam int STK_OVF  = 1;
    localparam int STK_UNF  = 2;
    localparam int STK_DISP = 3;

    // Code reported for event vector bit idx.
    function automatic logic [2:0] ev_code(input int idx);
        return 3'(idx + 1);
    endfunction

endpackage

// File: rtl/rx_status_lane.sv
// ----------------------------------------------------------------------------
// rx_status_lane
// One lane of the RxStatus tracker. It holds the pending event set, the
// priority encoder, the sticky error flags and the optional error counter.
//
// Optional feature macro: RX_STATUS_ERR_CNT_EN builds the saturating error
// counter. Without it err_cnt_o is tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst_n     block clock, asynchronous active-low reset
//   ev_i[6:0]      one-cycle event pulses, bit i reports as code i+1
//   clear_i        synchronous clear of the sticky flags and the counter
//   rx_status_o    registered RxStatus code
//   pending_o      events remain queued after this cycle
//   lost_o         pulse: a new event merged into an identical pending one
//   err_sticky_o   {Disparity, underflow, overflow, Decode}
//   err_cnt_o      saturating count of accepted error events
// ----------------------------------------------------------------------------
module rx_status_lane
    import rx_status_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_EV-1:0]    ev_i,
    input  logic                 clear_i,
    output logic [2:0]           rx_status_o,
    output logic                 pending_o,
    output logic                 lost_o,
    output logic [NUM_ERR-1:0]   err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [NUM_EV-1:0]  pend_q, pend_d;
    logic [2:0]         rx_status_q, rx_status_d;
    logic               pending_q, pending_d;
    logic               lost_q, lost_d;
    logic [NUM_ERR-1:0] sticky_q, sticky_d;

    logic [NUM_EV-1:0]  merged;
    logic [NUM_EV-1:0]  sel;
    logic [NUM_ERR-1:0] err_new;

    always_comb begin
        merged = pend_q | ev_i;

        // Ascending scan: the last hit is the highest set bit.
        sel         = '0;
        rx_status_d = CODE_IDLE;
        for (int i = 0; i < NUM_EV; i++) begin
            if (merged[i]) begin
                sel         = '0;
                sel[i]      = 1'b1;
                rx_status_d = ev_code(i);
            end
        end

        pend_d    = merged & ~sel;
        pending_d = |pend_d;
        // A repeat of an event that is still waiting is folded into it.
        lost_d    = |(pend_q & ev_i);

        err_new           = '0;
        err_new[STK_DEC]  = ev_i[EV_DEC_ERR];
        err_new[STK_OVF]  = ev_i[EV_OVERFLOW];
        err_new[STK_UNF]  = ev_i[EV_UNDERFLOW];
        err_new[STK_DISP] = ev_i[EV_DISP_ERR];

        // A new error on the same edge as clear_i still sets its flag.
        sticky_d = (clear_i ? '0 : sticky_q) | err_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            rx_status_q <= CODE_IDLE;
            pending_q   <= 1'b0;
            lost_q      <= 1'b0;
            sticky_q    <= '0;
        end else begin
            pend_q      <= pend_d;
            rx_status_q <= rx_status_d;
            pending_q   <= pending_d;
            lost_q      <= lost_d;
            sticky_q    <= sticky_d;
        end
    end

    assign rx_status_o  = rx_status_q;
    assign pending_o    = pending_q;
    assign lost_o       = lost_q;
    assign err_sticky_o = sticky_q;

`ifdef RX_STATUS_ERR_CNT_EN
    // Three guard bits hold base + 4 without wrapping, even for narrow widths.
    localparam int SUM_W = ERR_CNT_W + 3;
    localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {ERR_CNT_W{1'b1}}};

    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]     cnt_base;
    logic [SUM_W-1:0]     cnt_sum;

    always_comb begin
        cnt_base = clear_i ? '0 : {3'b000, cnt_q};
        cnt_sum  = cnt_base + SUM_W'(err_new[0]) + SUM_W'(err_new[1])
                            + SUM_W'(err_new[2]) + SUM_W'(err_new[3]);
        cnt_d    = (cnt_sum > CNT_MAX) ? {ERR_CNT_W{1'b1}}
                                       : cnt_sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign err_cnt_o = cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: rtl/rx_status_tracker.sv
// ----------------------------------------------------------------------------
// rx_status_tracker
// Registered multi-lane PIPE RxStatus tracker. Each lane queues one-cycle
// status pulses into a pending set, reports one event per cycle in RxStatus
// priority order (111 highest, 001 lowest) and keeps sticky error flags.
//
// Optional feature macro: RX_STATUS_ERR_CNT_EN adds a per-lane saturating
// error counter on err_cnt. Without it err_cnt is constant zero.
//
// Ports (lane i occupies slice i of every per-lane bus):
//   clk, rst_n            block clock, asynchronous active-low reset
//   skip_added .. Disparity_Error   per-lane one-cycle event pulses
//   clear_i               clears sticky flags and counters on all lanes
//   rx_status[3i+2:3i]    lane i code
//   pending_o[i]          lane i has events still queued
//   lost_o[i]             lane i coalesced a repeat event this cycle
//   err_sticky[4i+3:4i]   lane i {Disparity, underflow, overflow, Decode}
//   err_cnt               lane i saturating error count, ERR_CNT_W bits
// ----------------------------------------------------------------------------
module rx_status_tracker
    import rx_status_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_LANES-1:0]           skip_added,
    input  logic [NUM_LANES-1:0]           skip_removed,
    input  logic [NUM_LANES-1:0]           receiver_detected,
    input  logic [NUM_LANES-1:0]           Decode_Error,
    input  logic [NUM_LANES-1:0]           overflow,
    input  logic [NUM_LANES-1:0]           underflow,
    input  logic [NUM_LANES-1:0]           Disparity_Error,
    input  logic                           clear_i,
    output logic [3*NUM_LANES-1:0]         rx_status,
    output logic [NUM_LANES-1:0]           pending_o,
    output logic [NUM_LANES-1:0]           lost_o,
    output logic [4*NUM_LANES-1:0]         err_sticky,
    output logic [ERR_CNT_W*NUM_LANES-1:0] err_cnt
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [NUM_EV-1:0] ev;

        assign ev[EV_SKIP_ADD]  = skip_added[g];
        assign ev[EV_SKIP_REM]  = skip_removed[g];
        assign ev[EV_RX_DET]    = receiver_detected[g];
        assign ev[EV_DEC_ERR]   = Decode_Error[g];
        assign ev[EV_OVERFLOW]  = overflow[g];
        assign ev[EV_UNDERFLOW] = underflow[g];
        assign ev[EV_DISP_ERR]  = Disparity_Error[g];

        rx_status_lane #(
            .ERR_CNT_W (ERR_CNT_W)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .ev_i         (ev),
            .clear_i      (clear_i),
            .rx_status_o  (rx_status[3*g +: 3]),
            .pending_o    (pending_o[g]),
            .lost_o       (lost_o[g]),
            .err_sticky_o (err_sticky[4*g +: 4]),
            .err_cnt_o    (err_cnt[ERR_CNT_W*g +: ERR_CNT_W])
        );
    end

endmodule

// File: tb/tb_rx_status_tracker.sv
// ----------------------------------------------------------------------------
// tb_rx_status_tracker
// Directed scenarios followed by random pulses on four lanes. Each cycle the
// outputs are compared with a reference model that tracks each lane's
// waiting events as a set of flags and pops the highest-priority one.
// ----------------------------------------------------------------------------
module tb_rx_status_tracker;

    localparam int NL   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NL-1:0]   skip_added, skip_removed, receiver_detected;
    logic [NL-1:0]   Decode_Error, overflow, underflow, Disparity_Error;
    logic            clear_i;
    logic [3*NL-1:0] rx_status;
    logic [NL-1:0]   pending_o, lost_o;
    logic [4*NL-1:0] err_sticky;
    logic [CW*NL-1:0] err_cnt;

    always #5 clk = ~clk;

    rx_status_tracker #(.NUM_LANES(NL), .ERR_CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .skip_added        (skip_added),
        .skip_removed      (skip_removed),
        .receiver_detected (receiver_detected),
        .Decode_Error      (Decode_Error),
        .overflow          (overflow),
        .underflow         (underflow),
        .Disparity_Error   (Disparity_Error),
        .clear_i           (clear_i),
        .rx_status         (rx_status),
        .pending_o         (pending_o),
        .lost_o            (lost_o),
        .err_sticky        (err_sticky),
        .err_cnt           (err_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: event e (0 = skip_added .. 6 = Disparity) reports as
    // code e+1; errors are events 3..6 and map to sticky bits 0..3.
    bit m_wait [NL][7];
    int m_code [NL];
    bit m_pnd  [NL];
    bit m_lost [NL];
    bit m_stk  [NL][4];
    int m_cnt  [NL];

    function automatic bit ev_bit(input int l, input int e);
        case (e)
            0:       return skip_added[l];
            1:       return skip_removed[l];
            2:       return receiver_detected[l];
            3:       return Decode_Error[l];
            4:       return overflow[l];
            5:       return underflow[l];
            default: return Disparity_Error[l];
        endcase
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            for (int e = 0; e < 7; e++) m_wait[l][e] = 0;
            for (int k = 0; k < 4; k++) m_stk[l][k] = 0;
            m_code[l] = 0; m_pnd[l] = 0; m_lost[l] = 0; m_cnt[l] = 0;
        end
    endtask

    task automatic model_step();
        for (int l = 0; l < NL; l++) begin
            int nerr = 0;
            m_lost[l] = 0;
            if (clear_i) begin
                for (int k = 0; k < 4; k++) m_stk[l][k] = 0;
                m_cnt[l] = 0;
            end
            for (int e = 0; e < 7; e++) begin
                if (ev_bit(l, e)) begin
                    if (m_wait[l][e]) m_lost[l] = 1;
                    m_wait[l][e] = 1;
                    if (e >= 3) begin
                        m_stk[l][e-3] = 1;
                        nerr++;
                    end
                end
            end
            m_cnt[l] = (m_cnt[l] + nerr > CMAX) ? CMAX : m_cnt[l] + nerr;
            m_code[l] = 0;
            for (int e = 6; e >= 0; e--) begin
                if (m_wait[l][e]) begin
                    m_code[l] = e + 1;
                    m_wait[l][e] = 0;
                    break;
                end
            end
            m_pnd[l] = 0;
            for (int e = 0; e < 7; e++) if (m_wait[l][e]) m_pnd[l] = 1;
        end
    endtask

    task automatic chk(input string tag, input int l, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s lane%0d observed=%0h expected=%0h", tag, l, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int l = 0; l < NL; l++) begin
            int exp_cnt;
`ifdef RX_STATUS_ERR_CNT_EN
            exp_cnt = m_cnt[l];
`else
            exp_cnt = 0;
`endif
            chk("rx_status",  l, 32'(rx_status[3*l +: 3]), m_code[l]);
            chk("pending_o",  l, 32'(pending_o[l]), 32'(m_pnd[l]));
            chk("lost_o",     l, 32'(lost_o[l]), 32'(m_lost[l]));
            chk("err_sticky", l, 32'(err_sticky[4*l +: 4]),
                {28'd0, m_stk[l][3], m_stk[l][2], m_stk[l][1], m_stk[l][0]});
            chk("err_cnt",    l, 32'(err_cnt[CW*l +: CW]), exp_cnt);
        end
    endtask

    task automatic idle_inputs();
        skip_added = '0; skip_removed = '0; receiver_detected = '0;
        Decode_Error = '0; overflow = '0; underflow = '0;
        Disparity_Error = '0; clear_i = 1'b0;
    endtask

    // One clock: the DUT and the model both consume the current inputs.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();

        // Reset state
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single skip_added on lane 0
        skip_added[0] = 1'b1;
        cycle();
        idle_inputs();
        chk("single_code", 0, 32'(rx_status[2:0]), 32'd1);
        chk("single_pend", 0, 32'(pending_o[0]), 32'd0);
        cycle();
        chk("single_idle", 0, 32'(rx_status[2:0]), 32'd0);

        // Three simultaneous events drain highest first
        skip_added[0] = 1'b1; Decode_Error[0] = 1'b1; Disparity_Error[0] = 1'b1;
        cycle();
        idle_inputs();
        chk("drain_1", 0, 32'(rx_status[2:0]), 32'd7);
        chk("drain_p1", 0, 32'(pending_o[0]), 32'd1);
        cycle();
        chk("drain_2", 0, 32'(rx_status[2:0]), 32'd4);
        chk("drain_p2", 0, 32'(pending_o[0]), 32'd1);
        cycle();
        chk("drain_3", 0, 32'(rx_status[2:0]), 32'd1);
        chk("drain_p3", 0, 32'(pending_o[0]), 32'd0);
        cycle();
        chk("drain_idle", 0, 32'(rx_status[2:0]), 32'd0);

        // Repeat Decode_Error while it waits behind Disparity_Error
        Decode_Error[0] = 1'b1; Disparity_Error[0] = 1'b1;
        cycle();
        idle_inputs();
        Decode_Error[0] = 1'b1;
        cycle();
        idle_inputs();
        chk("coal_lost", 0, 32'(lost_o[0]), 32'd1);
        chk("coal_code", 0, 32'(rx_status[2:0]), 32'd4);
        cycle();
        chk("coal_once", 0, 32'(rx_status[2:0]), 32'd0);
        chk("coal_lost_end", 0, 32'(lost_o[0]), 32'd0);

        // Asynchronous reset while lane 1 is mid-drain
        skip_added[1] = 1'b1; skip_removed[1] = 1'b1;
        receiver_detected[1] = 1'b1; overflow[1] = 1'b1;
        cycle();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_pend", 1, 32'(pending_o[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Lane independence: only lane 2 sees receiver_detected
        receiver_detected[2] = 1'b1;
        cycle();
        idle_inputs();
        chk("lane2_code", 2, 32'(rx_status), 32'(12'b000_011_000_000));
        cycle();

        // Continuous overflow+underflow: sticky and counter saturation
        for (int i = 0; i < 20; i++) begin
            overflow[0] = 1'b1; underflow[0] = 1'b1;
            cycle();
        end
        idle_inputs();
        chk("sat_sticky", 0, 32'(err_sticky[3:0]), 32'b0110);
`ifdef RX_STATUS_ERR_CNT_EN
        chk("sat_cnt", 0, 32'(err_cnt[CW-1:0]), 32'd15);
`else
        chk("cnt_tied", 0, 32'(err_cnt[CW-1:0]), 32'd0);
`endif
        clear_i = 1'b1;
        cycle();
        idle_inputs();
        chk("clr_sticky", 0, 32'(err_sticky[3:0]), 32'd0);
        chk("clr_cnt", 0, 32'(err_cnt[CW-1:0]), 32'd0);

        // Error coinciding with clear_i wins
        overflow[3] = 1'b1;
        cycle();
        clear_i = 1'b1; overflow[3] = 1'b0; Decode_Error[3] = 1'b1;
        cycle();
        idle_inputs();
        chk("clr_win_stk", 3, 32'(err_sticky[15:12]), 32'b0001);
`ifdef RX_STATUS_ERR_CNT_EN
        chk("clr_win_cnt", 3, 32'(err_cnt[CW*3 +: CW]), 32'd1);
`endif
        for (int i = 0; i < 8; i++) cycle();

        // Random pulses on all lanes
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < NL; l++) begin
                skip_added[l]        = ($urandom_range(0, 99) < 20);
                skip_removed[l]      = ($urandom_range(0, 99) < 20);
                receiver_detected[l] = ($urandom_range(0, 99) < 15);
                Decode_Error[l]      = ($urandom_range(0, 99) < 15);
                overflow[l]          = ($urandom_range(0, 99) < 10);
                underflow[l]         = ($urandom_range(0, 99) < 10);
                Disparity_Error[l]   = ($urandom_range(0, 99) < 10);
            end
            clear_i = ($urandom_range(0, 99) < 4);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_status_tracker.md
Name: rx_status_tracker

Overview:
- Registered, multi-lane successor to the combinational PIPE RxStatus encoder.
- Per lane, it captures one-cycle status event pulses into a pending set, so lower-priority events are queued rather than masked.
- It reports one pending event per cycle in PIPE RxStatus priority order and keeps sticky error flags.
- Sits between the rx datapath (elastic buffer, 8b/10b decoder, receiver detect) and the PIPE rx interface.

Parameters:
- NUM_LANES, 1, number of independent lanes; each lane has its own pending set, sticky flags and counters.
- ERR_CNT_W, 8, width of the per-lane saturating error counter (used only with RX_STATUS_ERR_CNT_EN).

Ports:
- clk  input  1  single block clock
- rst_n  input  1  asynchronous active-low reset
- skip_added  input  NUM_LANES  per-lane one-cycle event pulse
- skip_removed  input  NUM_LANES  per-lane one-cycle event pulse
- receiver_detected  input  NUM_LANES  per-lane one-cycle event pulse
- Decode_Error  input  NUM_LANES  per-lane one-cycle event pulse
- overflow  input  NUM_LANES  per-lane one-cycle event pulse
- underflow  input  NUM_LANES  per-lane one-cycle event pulse
- Disparity_Error  input  NUM_LANES  per-lane one-cycle event pulse
- clear_i  input  1  synchronous clear of sticky flags and counters, all lanes
- rx_status  output  3*NUM_LANES  lane i code in bits [3i+2:3i]
- pending_o  output  NUM_LANES  lane still holds unreported events after this cycle
- lost_o  output  NUM_LANES  one-cycle pulse: an event was coalesced into an already-pending identical event
- err_sticky  output  4*NUM_LANES  per lane, bit order {Disparity, underflow, overflow, Decode}
- err_cnt  output  ERR_CNT_W*NUM_LANES  per-lane saturating error count

Behaviour:
- Codes:
  - 001 skip_added
  - 010 skip_removed
  - 011 receiver_detected
  - 100 Decode_Error
  - 101 overflow
  - 110 underflow
  - 111 Disparity_Error
  - 000 idle
- Priority, highest first: 111 > 110 > 101 > 100 > 011 > 010 > 001.
- Per lane, each rising clk edge:
  - merged = pending | new event bits (7-bit set).
  - If merged is non-zero: rx_status <= code of the highest set bit; pending <= merged with that bit cleared.
  - Otherwise: rx_status <= 000.
- Latency: an event asserted in cycle N appears on rx_status in cycle N+1 if it is the highest in merged; otherwise it appears later in priority order.
- pending_o is registered and equals |pending after the update.
- lost_o <= 1 for one cycle when a new event bit is already set in pending. The event is not queued twice.
- Simultaneous events in one cycle:
  - All are queued.
  - They drain one per cycle, highest first: k distinct events produce k consecutive non-zero codes.
- A higher-priority event arriving while lower ones wait pre-empts them next cycle. Nothing is dropped except by coalescing.
- err_sticky bits:
  - Set when the corresponding event is accepted into merged.
  - Held until clear_i.
- clear_i:
  - Clears err_sticky and err_cnt next edge.
  - Does not touch pending or rx_status.
  - If an error event coincides with clear_i, the event wins: the sticky bit and count are set, with count = 1.
- rst_n low, asynchronous:
  - rx_status = 0, pending = 0, pending_o = 0, lost_o = 0, err_sticky = 0, err_cnt = 0.
  - Queued events are discarded mid-drain.
- Lanes are fully independent; there is no cross-lane interaction.

Optional Feature:
- RX_STATUS_ERR_CNT_EN defined:
  - Per lane, err_cnt increments by the number of error events (Decode, overflow, underflow, Disparity) accepted that cycle, 0..4.
  - Saturates at 2^ERR_CNT_W-1 and never wraps.
- Not defined:
  - No counter flops are built.
  - err_cnt is tied to 0.

Decomposition:
- Package rx_status_pkg holds:
  - localparams for the seven codes and idle.
  - Bit indices of the 7-bit event vector.
  - The sticky bit index order.
- Sub-module rx_status_lane holds one lane's pending set, encoder, sticky flags and counter. The top generates NUM_LANES instances and packs the outputs.

Test Plan:
- Single skip_added pulse on lane 0, cycle 5 -> rx_status[2:0]=001 in cycle 6, 000 in cycle 7; pending_o stays 0.
- skip_added, Decode_Error and Disparity_Error together in cycle 5 -> rx_status 111, 100, 001 in cycles 6, 7, 8, then 000; pending_o=1 in cycles 6-7.
- Decode_Error pulsed in cycle 5 and again in cycle 6 while queued behind Disparity_Error -> lost_o=1 in cycle 7; 100 reported exactly once.
- rst_n low in cycle 7 with 3 events pending -> all outputs 0 immediately; no codes after release.
- With RX_STATUS_ERR_CNT_EN and ERR_CNT_W=4: 20 cycles of overflow+underflow -> err_cnt saturates at 15; clear_i -> 0; err_sticky=0110 before clear, 0000 after.
- NUM_LANES=4, lane 2 only gets receiver_detected -> lane 2 reports 011; lanes 0, 1 and 3 stay 000.
